bcd_score_converter: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3) for the game score.

---
 rtl/bcd_score_converter_pkg.sv | 26 ++
 rtl/bcd_score_converter_add3.sv | 19 +
 rtl/bcd_score_converter.sv | 159 +++++++++++++++
 tb/tb_bcd_score_converter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_score_converter_pkg.sv
// Shared definitions for the score binary-to-BCD converter: FSM state
// encoding, digit geometry and a constant helper for the decimal limit.
package bcd_score_converter_pkg;

  // Width of one BCD digit.
  localparam int DIGIT_W = 4;

  // Conversion FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADJ   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  // 10^n, evaluated at elaboration time to size the saturation limit.
  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] r;
    r = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_converter_add3.sv
// Combinational shift-and-add-3 cell: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module bcd_score_converter_add3
  import bcd_score_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  // Conditional +3 correction of a single digit.
  always_comb begin
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end else begin
      adjusted = digit;
    end
  end

endmodule

// File: rtl/bcd_score_converter.sv
// Sequential binary-to-BCD converter for the game score. One ADJ/SHIFT
// pair per input bit gives a fixed, value-independent latency. bcd_out and
// overflow are only rewritten on completion so the display never sees a
// partially converted value.
module bcd_score_converter
  import bcd_score_converter_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int               BCD_W     = DIGIT_W * DIGITS;
  localparam int               ITER_W    = $clog2(BIN_W);
  localparam logic [31:0]      BCD_MAX   = pow10(DIGITS) - 32'd1;
  localparam logic [BCD_W-1:0] BCD_SAT   = {DIGITS{4'h9}};
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BIN_W - 1);

  conv_state_e        state_r;
  conv_state_e        state_nx_s;
  logic               load_s;
  logic               adj_s;
  logic               shift_s;
  logic               finish_s;
  logic               ovf_in_s;

  logic [BIN_W-1:0]   shreg_r;
  logic [BCD_W-1:0]   scratch_r;
  logic [BCD_W-1:0]   scratch_adj_s;
  logic [ITER_W-1:0]  iter_r;
  logic               ovf_flag_r;

  logic               busy_r;
  logic               done_r;
  logic [BCD_W-1:0]   bcd_out_r;
  logic               overflow_r;

  // Saturation decision is taken on the raw input, not on the scratch digits.
  assign ovf_in_s = (32'(bin_in) > BCD_MAX);

  // One add-3 cell per digit; all digits are corrected in parallel.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_score_converter_add3 u_add3 (
      .digit    (scratch_r[g*DIGIT_W +: DIGIT_W]),
      .adjusted (scratch_adj_s[g*DIGIT_W +: DIGIT_W])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    adj_s      = 1'b0;
    shift_s    = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s     = 1'b1;
          state_nx_s = ST_ADJ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ADJ: begin
        adj_s      = 1'b1;
        state_nx_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (iter_r == ITER_LAST) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_ADJ;
        end
      end
      ST_DONE: begin
        finish_s = 1'b1;
        // A new request is taken in the completion cycle for full throughput.
        if (start) begin
          load_s     = 1'b1;
          state_nx_s = ST_ADJ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Conversion datapath: capture, digit correction, and combined left shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r    <= '0;
      scratch_r  <= '0;
      iter_r     <= '0;
      ovf_flag_r <= 1'b0;
    end else if (load_s) begin
      shreg_r    <= bin_in;
      scratch_r  <= '0;
      iter_r     <= '0;
      ovf_flag_r <= ovf_in_s;
    end else if (adj_s) begin
      scratch_r <= scratch_adj_s;
    end else if (shift_s) begin
      // Bits leaving the top of the scratch register are dropped.
      scratch_r <= {scratch_r[BCD_W-2:0], shreg_r[BIN_W-1]};
      shreg_r   <= {shreg_r[BIN_W-2:0], 1'b0};
      iter_r    <= iter_r + ITER_W'(1);
    end else begin
      scratch_r <= scratch_r;
    end
  end

  // Registered status and result; result only moves on completion or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bcd_out_r  <= '0;
      overflow_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == ST_ADJ) || (state_nx_s == ST_SHIFT);
      done_r <= finish_s;
      if (finish_s) begin
        bcd_out_r  <= ovf_flag_r ? BCD_SAT : scratch_r;
        overflow_r <= ovf_flag_r;
      end else begin
        bcd_out_r  <= bcd_out_r;
        overflow_r <= overflow_r;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign bcd_out  = bcd_out_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_bcd_score_converter.sv
// Scoreboard bench for bcd_score_converter. A reference model tracks which
// start requests are accepted (from request timing alone) and queues the
// decimal result with its due cycle; a negedge monitor checks every cycle.
module tb_bcd_score_converter;

  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int LATENCY = 2 * BIN_W + 1;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [BIN_W-1:0]  bin_in = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [15:0]       bcd_out;
  logic              overflow;

  exp_t        sb_q[$];
  int          edge_n = 0;
  int          next_ok = 0;
  int          acc_edge = 0;
  bit          has_acc = 1'b0;
  bit          live = 1'b0;
  logic [15:0] last_bcd = 16'h0000;
  logic        last_ovf = 1'b0;
  int          vectors = 0;
  int          errors = 0;

  bcd_score_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .bin_in   (bin_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Decimal reference: saturate above 9999, else one digit per nibble.
  function automatic exp_t ref_model(input int v);
    exp_t e;
    e.due = 0;
    if (v > 9999) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      e.bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, edge_n);
    end
  endtask

  // Acceptance model: a request is taken when the converter is idle or completing.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (reset) begin
      live     = 1'b1;
      sb_q.delete();
      has_acc  = 1'b0;
      next_ok  = edge_n + 1;
      last_bcd = 16'h0000;
      last_ovf = 1'b0;
    end else if (start && edge_n >= next_ok) begin
      exp_t e;
      e = ref_model(int'(bin_in));
      e.due = edge_n + LATENCY;
      sb_q.push_back(e);
      acc_edge = edge_n;
      has_acc  = 1'b1;
      next_ok  = edge_n + LATENCY;
    end
  end

  // Monitor: status every cycle, result on due cycles, hold otherwise.
  always @(negedge clk) begin
    if (live) begin
      logic exp_busy;
      logic exp_done;
      exp_busy = has_acc && (edge_n - acc_edge < LATENCY - 1);
      exp_done = (sb_q.size() != 0) && (sb_q[0].due == edge_n);
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        exp_t e;
        e = sb_q.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(e.bcd));
        check("overflow", 32'(overflow), 32'(e.ovf));
        last_bcd = e.bcd;
        last_ovf = e.ovf;
      end else begin
        check("bcd_hold", 32'(bcd_out), 32'(last_bcd));
        check("ovf_hold", 32'(overflow), 32'(last_ovf));
      end
    end
  end

  // One start pulse, then wait (bounded) for the converter to finish.
  task automatic send(input int v);
    start  = 1'b1;
    bin_in = BIN_W'(v);
    @(negedge clk);
    start  = 1'b0;
    bin_in = BIN_W'($urandom);
    for (int i = 0; i < LATENCY + 4; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    @(negedge clk);
  endtask

  initial begin
    int fixed_vals[8] = '{1234, 0, 9, 10, 9999, 10000, 16383, 42};

    // Reset held three cycles.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed values, including the decimal limit and saturation cases.
    foreach (fixed_vals[i]) send(fixed_vals[i]);

    // start held high: back-to-back conversions, input changed after capture.
    start  = 1'b1;
    bin_in = 14'd77;
    repeat (3) @(negedge clk);
    bin_in = 14'd5;
    repeat (2 * LATENCY + 5) @(negedge clk);
    start = 1'b0;
    repeat (LATENCY + 2) @(negedge clk);

    // Pulses while busy are ignored.
    start  = 1'b1;
    bin_in = 14'd808;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start  = (i % 2 == 0);
      bin_in = BIN_W'($urandom);
      repeat (3) @(negedge clk);
    end
    start = 1'b0;
    repeat (LATENCY) @(negedge clk);

    // Reset mid-conversion aborts, then a clean conversion.
    start  = 1'b1;
    bin_in = 14'd5555;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (LATENCY + 3) @(negedge clk);
    send(321);

    // Randomized values with random extra start pulses.
    for (int n = 0; n < 30; n++) begin
      int v;
      int gap;
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383))
                                      : int'($urandom_range(0, 9999));
      start  = 1'b1;
      bin_in = BIN_W'(v);
      @(negedge clk);
      gap = int'($urandom_range(0, 35));
      for (int k = 0; k < gap; k++) begin
        start  = ($urandom_range(0, 7) == 0);
        bin_in = BIN_W'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end

    // Drain outstanding results with a bound.
    for (int i = 0; i < 2 * LATENCY; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    vectors++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
